regfile_32: RTL and testbench

//  MIPS register file: 32 x 32-bit general registers, two async read ports, one sync write port.

---
 rtl/regfile_32.sv | 75 +++++++
 tb/tb_regfile_32.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_32.sv
// MIPS 32x32 register file: two async read ports, one sync write port, debug read, write counter.
// Optional write-to-read forwarding on the operand ports when REGFILE_BYPASS_EN is defined.

module regfile_32_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module regfile_32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic                        wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  // $zero has no storage; entry 0 is a constant so every read path sees 0 for free
  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    regfile_32_reg #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (reg_write && (write_reg == ADDR_W'(i))),
      .d     (write_data),
      .q     (regs[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_count <= '0;
    else if (wr_en) wr_count <= wr_count + 32'd1;
  end

  assign dbg_data = regs[dbg_addr];

`ifdef REGFILE_BYPASS_EN
  // forwarding is masked during reset so the outputs stay at 0 while rst_n is low
  logic fwd1, fwd2;
  assign fwd1 = rst_n && wr_en && (write_reg == read_reg1);
  assign fwd2 = rst_n && wr_en && (write_reg == read_reg2);
  assign read_data1 = fwd1 ? write_data : regs[read_reg1];
  assign read_data2 = fwd2 ? write_data : regs[read_reg2];
`else
  assign read_data1 = regs[read_reg1];
  assign read_data2 = regs[read_reg2];
`endif

endmodule

// File: tb/tb_regfile_32.sv
// Directed-vector bench for regfile_32; expected values are hand-computed constants.
// Build with +define+REGFILE_BYPASS_EN to check the forwarding variant.

module tb_regfile_32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic [31:0] write_data;
  logic [31:0] read_data1, read_data2, dbg_data, wr_count;

  int nvec = 0;
  int nerr = 0;

  regfile_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    @(posedge clk);
    #1;
    reg_write  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; reg_write = 1'b0;
    read_reg1 = '0; read_reg2 = '0; write_reg = '0; dbg_addr = '0;
    write_data = '0;

    // reset state
    #3;
    read_reg1 = 5'd7; read_reg2 = 5'd12; dbg_addr = 5'd20;
    #1;
    chk("rst_rd1", read_data1, 32'h0);
    chk("rst_rd2", read_data2, 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    chk("rst_cnt", wr_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: preload $5, then async reset mid-cycle clears it before any edge
    wr(5'd5, 32'hDEADBEEF);
    read_reg1 = 5'd5; #1;
    chk("t1_pre", read_data1, 32'hDEADBEEF);
    chk("t1_cnt_pre", wr_count, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rd1", read_data1, 32'h0);
    chk("t1_cnt", wr_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: write then read on both ports
    wr(5'd8, 32'h0000_1234);
    read_reg1 = 5'd8; read_reg2 = 5'd8; #1;
    chk("t2_rd1", read_data1, 32'h1234);
    chk("t2_rd2", read_data2, 32'h1234);
    chk("t2_cnt", wr_count, 32'd1);

    // 3: writes to $zero are dropped and not counted
    wr(5'd0, 32'hFFFF_FFFF);
    read_reg1 = 5'd0; dbg_addr = 5'd0; #1;
    chk("t3_rd1", read_data1, 32'h0);
    chk("t3_dbg", dbg_data, 32'h0);
    chk("t3_cnt", wr_count, 32'd1);
    read_reg2 = 5'd8; #1;
    chk("t3_r8", read_data2, 32'h1234);

    // 4: read-during-write on $9
    wr(5'd9, 32'hA);
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hB;
    read_reg1 = 5'd9; read_reg2 = 5'd8; dbg_addr = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t4_before", read_data1, 32'hB);
`else
    chk("t4_before", read_data1, 32'hA);
`endif
    chk("t4_rd2_other", read_data2, 32'h1234);
    chk("t4_dbg_before", dbg_data, 32'hA);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    chk("t4_after", read_data1, 32'hB);
    chk("t4_dbg_after", dbg_data, 32'hB);
    chk("t4_cnt", wr_count, 32'd3);

    // 5: reset wins over a write on the same edge
    @(negedge clk);
    rst_n = 1'b0;
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h55; read_reg1 = 5'd3;
    #1;
    chk("t5_rd_in_rst", read_data1, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reg_write = 1'b0;
    rst_n = 1'b1;
    dbg_addr = 5'd3; #1;
    chk("t5_r3", dbg_data, 32'h0);
    chk("t5_cnt", wr_count, 32'h0);
    wr(5'd31, 32'h7FFF_FFFC);
    dbg_addr = 5'd31; #1;
    chk("t5_r31", dbg_data, 32'h7FFF_FFFC);
    chk("t5_cnt1", wr_count, 32'd1);

    // write enable low must leave registers alone regardless of write_data
    @(negedge clk);
    write_reg = 5'd31; write_data = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    chk("t5_nowe", dbg_data, 32'h7FFF_FFFC);
    chk("t5_nowe_cnt", wr_count, 32'd1);

    // 6: sweep all registers after a fresh reset
    pulse_reset();
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 1; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(32 - i);
      dbg_addr  = 5'(i);
      #1;
      chk($sformatf("t6_rd1_%0d", i), read_data1, 32'(i) * 32'h0101_0101);
      chk($sformatf("t6_rd2_%0d", 32 - i), read_data2, 32'(32 - i) * 32'h0101_0101);
      chk($sformatf("t6_dbg_%0d", i), dbg_data, 32'(i) * 32'h0101_0101);
    end
    chk("t6_cnt", wr_count, 32'd31);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
